// File: rtl/prio_enc_handshake.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : prio_enc_handshake                                       |
// | Description : Captures rising edges on N request lines into a pending  |
// |               set and drains it lowest-index-first through a           |
// |               valid/ready handshake, one encoded index per transfer.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module prio_enc_handshake #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [W-1:0] y,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pend
);

    localparam logic [0:0]   c_IDLE  = 1'b0;
    localparam logic [0:0]   c_OFFER = 1'b1;
    localparam logic [N-1:0] c_ONE   = N'(1);

    logic [0:0]   r_state;
    logic [N-1:0] r_req_q;
    logic [N-1:0] r_pend;
    logic [W-1:0] r_y;

    logic [N-1:0] w_rise;
    logic [W-1:0] w_idx;
    logic         w_any;
    logic         w_load;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_pend_next;

    // Edge detection on the request lines, independent of the capture enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_q <= '0;
        end else begin
            r_req_q <= req;
        end
    end

    assign w_rise = req & ~r_req_q;

    // Lowest set index of the registered pending set wins
    always_comb begin
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_idx = i[W-1:0];
            end
        end
    end

    assign w_any = |r_pend;

    // A new index is loaded when idle, or when the current one is accepted;
    // only registered pend is consulted, so a rise never reaches y the same cycle
    assign w_load      = w_any && ((r_state == c_IDLE) || ready);
    assign w_clr       = w_load ? (c_ONE << w_idx) : '0;
    assign w_pend_next = (r_pend & ~w_clr) | (w_rise & {N{en}});

    // Pending set: clear of the loaded bit, with a same-cycle rise winning
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    // Offer state machine: IDLE loads on nonempty pend, OFFER holds until ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_y     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_load) begin
                        r_y     <= w_idx;
                        r_state <= c_OFFER;
                    end
                end
                c_OFFER: begin
                    if (ready) begin
                        if (w_load) begin
                            r_y <= w_idx;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign y     = r_y;
    assign valid = (r_state == c_OFFER);
    assign pend  = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_prio_enc_handshake.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_prio_enc_handshake                                    |
// | Description : Scenario bench for prio_enc_handshake; expected indices  |
// |               queue up as events are driven and are matched against    |
// |               each accepted transfer.                                  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_prio_enc_handshake;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [N-1:0] req;
    logic [W-1:0] y;
    logic         valid;
    logic         ready;
    logic [N-1:0] pend;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];

    prio_enc_handshake #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req),
        .y     (y),
        .valid (valid),
        .ready (ready),
        .pend  (pend)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every accepted transfer must match the oldest expected index
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got y=%0d, required no transfer", y);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (y !== e) begin
                    n_err++;
                    $display("FAIL sb_transfer: got y=%0d, required y=%0d", y, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drained: got %0d outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        ready = 1'b0;
        #2;
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", valid); end
        n_vec++;
        if (y !== 2'd0) begin n_err++; $display("FAIL reset_y: got %0d, required 0", y); end
        n_vec++;
        if (pend !== 4'b0000) begin n_err++; $display("FAIL reset_pend: got %b, required 0000", pend); end
        step();
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_single();
        en    = 1'b1;
        ready = 1'b1;
        req   = 4'b0100;
        exp_q.push_back(2'd2);
        step();
        n_vec++;
        if (pend !== 4'b0100) begin n_err++; $display("FAIL single_pend: got %b, required 0100", pend); end
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL single_valid_e0: got %b, required 0", valid); end
        step();
        n_vec++;
        if (valid !== 1'b1 || y !== 2'd2) begin
            n_err++; $display("FAIL single_offer: got valid=%b y=%0d, required valid=1 y=2", valid, y);
        end
        step();
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL single_valid_e2: got %b, required 0", valid); end
        req = 4'b0000;
        step();
        check_drained("single");
    endtask

    task automatic test_simultaneous();
        ready = 1'b1;
        req   = 4'b1010;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        step();
        n_vec++;
        if (pend !== 4'b1010) begin n_err++; $display("FAIL simul_pend: got %b, required 1010", pend); end
        step();
        n_vec++;
        if (valid !== 1'b1 || y !== 2'd1) begin
            n_err++; $display("FAIL simul_first: got valid=%b y=%0d, required valid=1 y=1", valid, y);
        end
        step();
        n_vec++;
        if (valid !== 1'b1 || y !== 2'd3) begin
            n_err++; $display("FAIL simul_second: got valid=%b y=%0d, required valid=1 y=3", valid, y);
        end
        step();
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL simul_idle: got %b, required 0", valid); end
        req = 4'b0000;
        step();
        step();
        check_drained("simul");
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        req   = 4'b1010;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (valid !== 1'b1 || y !== 2'd1) begin
                n_err++; $display("FAIL bp_hold_%0d: got valid=%b y=%0d, required valid=1 y=1", k, valid, y);
            end
            step();
        end
        ready = 1'b1;
        step();
        n_vec++;
        if (valid !== 1'b1 || y !== 2'd3) begin
            n_err++; $display("FAIL bp_next: got valid=%b y=%0d, required valid=1 y=3", valid, y);
        end
        step();
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL bp_idle: got %b, required 0", valid); end
        req = 4'b0000;
        step();
        check_drained("bp");
    endtask

    task automatic test_enable();
        en    = 1'b0;
        ready = 1'b1;
        req   = 4'b0001;
        step();
        n_vec++;
        if (pend !== 4'b0000) begin n_err++; $display("FAIL en_gated_pend: got %b, required 0000", pend); end
        step();
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL en_gated_valid: got %b, required 0", valid); end
        en = 1'b1;
        step();
        step();
        n_vec++;
        if (pend !== 4'b0000 || valid !== 1'b0) begin
            n_err++; $display("FAIL en_held: got pend=%b valid=%b, required pend=0000 valid=0", pend, valid);
        end
        req = 4'b0000;
        step();
        req = 4'b0001;
        exp_q.push_back(2'd0);
        step();
        n_vec++;
        if (pend !== 4'b0001) begin n_err++; $display("FAIL en_retoggle_pend: got %b, required 0001", pend); end
        step();
        n_vec++;
        if (valid !== 1'b1 || y !== 2'd0) begin
            n_err++; $display("FAIL en_retoggle_offer: got valid=%b y=%0d, required valid=1 y=0", valid, y);
        end
        step();
        req = 4'b0000;
        step();
        check_drained("en");
    endtask

    task automatic test_rearm();
        ready = 1'b0;
        req   = 4'b0100;
        exp_q.push_back(2'd2);
        step();
        step();
        n_vec++;
        if (valid !== 1'b1 || y !== 2'd2 || pend !== 4'b0000) begin
            n_err++; $display("FAIL rearm_offer: got valid=%b y=%0d pend=%b, required valid=1 y=2 pend=0000", valid, y, pend);
        end
        req = 4'b0000;
        step();
        req = 4'b0100;
        exp_q.push_back(2'd2);
        step();
        n_vec++;
        if (pend !== 4'b0100 || y !== 2'd2 || valid !== 1'b1) begin
            n_err++; $display("FAIL rearm_pend: got pend=%b y=%0d valid=%b, required pend=0100 y=2 valid=1", pend, y, valid);
        end
        ready = 1'b1;
        step();
        n_vec++;
        if (valid !== 1'b1 || y !== 2'd2 || pend !== 4'b0000) begin
            n_err++; $display("FAIL rearm_second: got valid=%b y=%0d pend=%b, required valid=1 y=2 pend=0000", valid, y, pend);
        end
        step();
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL rearm_idle: got %b, required 0", valid); end
        req = 4'b0000;
        step();
        check_drained("rearm");
    endtask

    task automatic test_back_to_back();
        ready = 1'b1;
        req   = 4'b0001;
        exp_q.push_back(2'd0);
        step();
        req = 4'b0011;
        exp_q.push_back(2'd1);
        step();
        n_vec++;
        if (valid !== 1'b1 || y !== 2'd0 || pend !== 4'b0010) begin
            n_err++; $display("FAIL b2b_first: got valid=%b y=%0d pend=%b, required valid=1 y=0 pend=0010", valid, y, pend);
        end
        step();
        n_vec++;
        if (valid !== 1'b1 || y !== 2'd1) begin
            n_err++; $display("FAIL b2b_second: got valid=%b y=%0d, required valid=1 y=1", valid, y);
        end
        step();
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b, required 0", valid); end
        req = 4'b0000;
        step();
        check_drained("b2b");
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        en    = 1'b1;
        req   = 4'b0111;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        step();
        step();
        n_vec++;
        if (pend !== 4'b0110 || valid !== 1'b1 || y !== 2'd0) begin
            n_err++; $display("FAIL rstmid_pre: got pend=%b valid=%b y=%0d, required pend=0110 valid=1 y=0", pend, valid, y);
        end
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        req = 4'b0001;
        #1;
        n_vec++;
        if (valid !== 1'b0 || y !== 2'd0 || pend !== 4'b0000) begin
            n_err++; $display("FAIL rstmid_async: got valid=%b y=%0d pend=%b, required valid=0 y=0 pend=0000", valid, y, pend);
        end
        step();
        rst_n = 1'b1;
        exp_q.push_back(2'd0);
        step();
        n_vec++;
        if (pend !== 4'b0001 || valid !== 1'b0) begin
            n_err++; $display("FAIL rstmid_capture: got pend=%b valid=%b, required pend=0001 valid=0", pend, valid);
        end
        step();
        n_vec++;
        if (valid !== 1'b1 || y !== 2'd0) begin
            n_err++; $display("FAIL rstmid_offer: got valid=%b y=%0d, required valid=1 y=0", valid, y);
        end
        ready = 1'b1;
        step();
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %b, required 0", valid); end
        req = 4'b0000;
        step();
        check_drained("rstmid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_enable();
        test_rearm();
        test_back_to_back();
        test_reset_mid();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
